keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by time-multiplexing the column drives and reading the rows.
- This is the input counterpart of the display multiplexer.
- Debounces one key at a time, converts it to a 4-bit hex code, and shifts it into a two-digit history that feeds the dual seven-segment display path.
- Sits between the keypad pins and the display mux; runs on the internal oscillator.

Parameters:
- SCAN_DIV, 6000: IntOsc cycles per scan tick (1 kHz at 6 MHz). Legal minimum is 4.
- DEBOUNCE_SCANS, 20: consecutive stable scan ticks needed to accept a press or a release.
- REPEAT_SCANS, 500: scan ticks a key must be held before auto-repeat. Used only with KEYPAD_REPEAT_EN.

Ports:
- IntOsc  input  1  system clock (6 MHz internal oscillator).
- Reset  input  1  asynchronous, active-low reset.
- Rows  input  4  keypad rows, active-low, pulled up externally, asynchronous to IntOsc.
- Cols  output  4  column drive, active-low one-hot (exactly one bit 0 at all times).
- KeyCode  output  4  hex code of the last accepted key.
- KeyValid  output  1  one-cycle pulse when a key is accepted.
- Digit1  output  4  most recent accepted key (left display).
- Digit0  output  4  previous accepted key (right display).

Behaviour:
- Reset (Reset=0, asynchronous):
  - Cols=4'b1110 (column 0), KeyCode=0, KeyValid=0, Digit1=0, Digit0=0.
  - State SCAN; tick counter, debounce counter and repeat counter all 0.
  - The Rows synchronizer flops reset to 4'b1111.
- Rows pass through a 2-flop synchronizer before any use.
- Tick generator:
  - Free-running counter 0..SCAN_DIV-1.
  - Tick asserts for one cycle when the counter equals SCAN_DIV-1, then the counter wraps to 0.
  - Cols changes only on the cycle after a tick, so rows settle for SCAN_DIV cycles before the next sample.
- Row priority: if several rows are low in the driven column, the lowest row index wins. Keys in other columns are ignored while the FSM is outside SCAN.
- State machine (all decisions are taken only on tick cycles):
  - SCAN:
    - Any synced row low: capture (col,row), freeze Cols, debounce count=1, go to DEBOUNCE.
    - Otherwise advance column 0→1→2→3→0 (wrap).
  - DEBOUNCE:
    - Captured row still low: count+1.
    - Count reaches DEBOUNCE_SCANS: accept the key and go to HELD.
    - Captured row high: abandon, advance column, go to SCAN. No output.
  - HELD:
    - Captured row high: count=1, go to RELEASE.
    - Otherwise stay.
  - RELEASE:
    - Row high: count+1. Count reaches DEBOUNCE_SCANS: advance column, go to SCAN.
    - Row low again: go to HELD (bounce on release produces no new key).
- Accept action (registered, one cycle after the qualifying tick):
  - KeyValid=1 for exactly one IntOsc cycle.
  - KeyCode=code.
  - Digit0<=Digit1, Digit1<=code.
- Key map (row0..row3 by col0..col3):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- Latency: press stable from a SCAN-sampled tick gives KeyValid (DEBOUNCE_SCANS-1) ticks later plus 1 cycle.
- Counter widths: debounce and repeat counters saturate and never wrap.
- Reset mid-operation: an immediate return to the reset values; no KeyValid is emitted.

Optional Feature:
- KEYPAD_REPEAT_EN defined:
  - In HELD, a repeat counter increments each tick while the key is held.
  - When it reaches REPEAT_SCANS, the accept action repeats with the same code and the repeat counter clears.
  - Result: one KeyValid per REPEAT_SCANS ticks while held.
  - The repeat counter clears on entry to HELD and in RELEASE.
- KEYPAD_REPEAT_EN undefined: the repeat logic is absent and a held key produces exactly one KeyValid.

Test Plan:
- All tests use SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=5.
1. Reset release, no keys → Cols cycles 1110,1101,1011,0111,1110 at one change per 4 cycles; KeyValid stays 0; Digit1/Digit0 = 0.
2. Press row1/col2 clean for 10 ticks → one KeyValid pulse; KeyCode=6; Digit1=6, Digit0=0; Cols frozen at 1011 until the release completes.
3. Press row2/col0 (7), release, then press row3/col1 (0) → two KeyValid pulses; final Digit1=0, Digit0=7.
4. Bounce row0/col3 low 1 tick, high 1 tick, then held low 5 ticks → exactly one KeyValid; KeyCode=A. Release bounce high 1 tick, low 1 tick, high 4 ticks → no extra pulse; scanning resumes.
5. Rows 0 and 2 low together in col1 → KeyCode=2. Reset asserted mid-DEBOUNCE → all outputs at reset values immediately, no KeyValid.
6. With KEYPAD_REPEAT_EN, hold key 9 for 20 ticks past acceptance → 1+4 KeyValid pulses spaced 5 ticks apart, KeyCode=9. Without the macro → exactly 1 pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scanner with debounce and two-digit history; KEYPAD_REPEAT_EN adds auto-repeat
module keypad_scanner #(
  parameter int SCAN_DIV       = 6000,
  parameter int DEBOUNCE_SCANS = 20,
  parameter int REPEAT_SCANS   = 500
) (
  input  logic       IntOsc,
  input  logic       Reset,
  input  logic [3:0] Rows,
  output logic [3:0] Cols,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  output logic [3:0] Digit1,
  output logic [3:0] Digit0
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  logic [3:0]    rows_meta;
  logic [3:0]    rows_sync;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  state_t        state;
  logic [1:0]    col;
  logic [1:0]    cap_row;
  logic [1:0]    sel_row;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_next;
  logic          any_low;
  logic          cap_low;
  logic          deb_done;
  logic          accept;
  logic [3:0]    code;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_next;
  logic          rep_done;
`endif

  // Two-flop synchronizer: keypad rows are asynchronous to IntOsc
  always_ff @(posedge IntOsc or negedge Reset) begin
    if (!Reset) begin
      rows_meta <= 4'b1111;
      rows_sync <= 4'b1111;
    end else begin
      rows_meta <= Rows;
      rows_sync <= rows_meta;
    end
  end

  // Scan tick divider: one-cycle tick every SCAN_DIV cycles
  always_ff @(posedge IntOsc or negedge Reset) begin
    if (!Reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Row priority, saturating counter arithmetic and the accept decision
  always_comb begin
    tick    = (tick_cnt == TW'(SCAN_DIV - 1));
    any_low = ~&rows_sync;
    sel_row = 2'd3;
    if (!rows_sync[2]) sel_row = 2'd2;
    if (!rows_sync[1]) sel_row = 2'd1;
    if (!rows_sync[0]) sel_row = 2'd0;
    cap_low  = ~rows_sync[cap_row];
    deb_next = (deb_cnt >= DW'(DEBOUNCE_SCANS)) ? deb_cnt : deb_cnt + DW'(1);
    deb_done = (deb_next == DW'(DEBOUNCE_SCANS));
    accept   = tick && (state == DEBOUNCE) && cap_low && deb_done;
`ifdef KEYPAD_REPEAT_EN
    rep_next = (rep_cnt >= RW'(REPEAT_SCANS)) ? rep_cnt : rep_cnt + RW'(1);
    rep_done = (rep_next == RW'(REPEAT_SCANS));
    if (tick && (state == HELD) && cap_low && rep_done) accept = 1'b1;
`endif
  end

  // Key map lookup for the captured row in the frozen column
  always_comb begin
    code = 4'h0;
    case ({cap_row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
  end

  // Scan/debounce FSM: decisions only on ticks, column frozen outside SCAN
  always_ff @(posedge IntOsc or negedge Reset) begin
    if (!Reset) begin
      state   <= SCAN;
      col     <= 2'd0;
      Cols    <= 4'b1110;
      cap_row <= 2'd0;
      deb_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt <= '0;
`endif
    end else if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            cap_row <= sel_row;
            deb_cnt <= DW'(1);
            state   <= DEBOUNCE;
          end else begin
            col  <= col + 2'd1;
            Cols <= {Cols[2:0], Cols[3]};
          end
        end
        DEBOUNCE: begin
          if (cap_low) begin
            deb_cnt <= deb_next;
            if (deb_done) begin
              state <= HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt <= '0;
`endif
            end
          end else begin
            col   <= col + 2'd1;
            Cols  <= {Cols[2:0], Cols[3]};
            state <= SCAN;
          end
        end
        HELD: begin
          if (!cap_low) begin
            deb_cnt <= DW'(1);
            state   <= RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else begin
            rep_cnt <= rep_done ? '0 : rep_next;
          end
`else
          else begin
            state <= HELD;
          end
`endif
        end
        default: begin
`ifdef KEYPAD_REPEAT_EN
          rep_cnt <= '0;
`endif
          if (!cap_low) begin
            deb_cnt <= deb_next;
            if (deb_done) begin
              col   <= col + 2'd1;
              Cols  <= {Cols[2:0], Cols[3]};
              state <= SCAN;
            end
          end else begin
            state <= HELD;
          end
        end
      endcase
    end
  end

  // Registered accept action: one-cycle pulse, code and history shift
  always_ff @(posedge IntOsc or negedge Reset) begin
    if (!Reset) begin
      KeyValid <= 1'b0;
      KeyCode  <= 4'h0;
      Digit1   <= 4'h0;
      Digit0   <= 4'h0;
    end else begin
      KeyValid <= accept;
      if (accept) begin
        KeyCode <= code;
        Digit1  <= code;
        Digit0  <= Digit1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - table, directed and randomized checks of keypad_scanner
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int RP = 5;

  logic        IntOsc = 1'b0;
  logic        Reset;
  logic [3:0]  Rows;
  logic [3:0]  Cols;
  logic [3:0]  KeyCode;
  logic        KeyValid;
  logic [3:0]  Digit1;
  logic [3:0]  Digit0;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model state: run lengths of the locked key
  int         m_col;
  int         m_cand;
  bit         m_acc;
  int         m_run;
  int         m_rel;
  int         m_hold;
  bit         m_valid;
  logic [3:0] m_code;
  logic [3:0] m_d1;
  logic [3:0] m_d0;
  logic [3:0] hexmap [16];

  typedef struct {
    logic [15:0] mask;
    int          ticks;
    int          npulse;
    logic [3:0]  code;
    logic [3:0]  d1;
    logic [3:0]  d0;
    logic [3:0]  cols;
  } vec_t;
  vec_t tbl [12];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_SCANS(RP)) dut (
    .IntOsc(IntOsc), .Reset(Reset), .Rows(Rows), .Cols(Cols),
    .KeyCode(KeyCode), .KeyValid(KeyValid), .Digit1(Digit1), .Digit0(Digit0)
  );

  always #5 IntOsc = ~IntOsc;

  // Keypad matrix: a pressed key pulls its row low when its column is driven
  always_comb begin
    Rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !Cols[c]) Rows[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_cand = -1; m_acc = 0; m_run = 0; m_rel = 0; m_hold = 0;
    m_valid = 0; m_code = 4'h0; m_d1 = 4'h0; m_d0 = 4'h0;
  endtask

  task automatic emit();
    m_valid = 1;
    m_code  = hexmap[m_cand*4+m_col];
    m_d0    = m_d1;
    m_d1    = m_code;
  endtask

  task automatic model_step();
    bit down;
    m_valid = 0;
    if (m_cand < 0) begin
      for (int r = 3; r >= 0; r--)
        if (keys[r*4+m_col]) m_cand = r;
      if (m_cand >= 0) m_run = 1;
      else m_col = (m_col + 1) % 4;
    end else begin
      down = keys[m_cand*4+m_col];
      if (!m_acc) begin
        if (down) begin
          m_run++;
          if (m_run == DB) begin
            emit();
            m_acc = 1; m_rel = 0; m_hold = 0;
          end
        end else begin
          m_cand = -1;
          m_col = (m_col + 1) % 4;
        end
      end else if (down) begin
        if (m_rel > 0) begin
          m_rel = 0; m_hold = 0;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          m_hold++;
          if (m_hold == RP) begin
            emit();
            m_hold = 0;
          end
`endif
        end
      end else begin
        m_rel++;
        if (m_rel == DB) begin
          m_cand = -1; m_acc = 0; m_rel = 0;
          m_col = (m_col + 1) % 4;
        end
      end
    end
  endtask

  // One scan period: four cycles, the fourth posedge is the tick
  task automatic do_tick();
    logic [3:0] ec;
    bit ev;
    for (int i = 0; i < SD; i++) begin
      @(posedge IntOsc);
      ev = 0;
      if (i == SD - 1) begin
        model_step();
        ev = m_valid;
      end
      @(negedge IntOsc);
      if (KeyValid === 1'b1) pulses++;
      ec = 4'b1111 ^ (4'b0001 << m_col);
      chk("keyvalid", {19'd0, KeyValid}, {19'd0, ev});
      chk("outputs", {4'd0, Cols, KeyCode, Digit1, Digit0}, {4'd0, ec, m_code, m_d1, m_d0});
    end
  endtask

  task automatic run(input logic [15:0] mask, input int n);
    keys = mask;
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic wait_col(input int c);
    int n;
    n = 0;
    keys = 16'h0;
    while ((m_col != c || m_cand >= 0) && n < 16) begin
      do_tick();
      n++;
    end
    if (m_col != c) begin
      checks++;
      errors++;
      $display("FAIL wait_col actual=%0d expected=%0d", m_col, c);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] scan_exp [4];
    logic [15:0] rmask;
    int sel;

    hexmap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    scan_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    tbl[0]  = '{16'h0040, 7, 1, 4'h6, 4'h6, 4'h0, 4'b1011};
    tbl[1]  = '{16'h0000, 5, 0, 4'h6, 4'h6, 4'h0, 4'b1101};
    tbl[2]  = '{16'h0100, 7, 1, 4'h7, 4'h7, 4'h6, 4'b1110};
    tbl[3]  = '{16'h0000, 5, 0, 4'h7, 4'h7, 4'h6, 4'b0111};
    tbl[4]  = '{16'h2000, 7, 1, 4'h0, 4'h0, 4'h7, 4'b1101};
    tbl[5]  = '{16'h0000, 5, 0, 4'h0, 4'h0, 4'h7, 4'b1110};
    tbl[6]  = '{16'h0202, 7, 1, 4'h2, 4'h2, 4'h0, 4'b1101};
    tbl[7]  = '{16'h0000, 5, 0, 4'h2, 4'h2, 4'h0, 4'b1110};
    tbl[8]  = '{16'h8000, 7, 1, 4'hD, 4'hD, 4'h2, 4'b0111};
    tbl[9]  = '{16'h0000, 5, 0, 4'hD, 4'hD, 4'h2, 4'b1011};
    tbl[10] = '{16'h1000, 7, 1, 4'hE, 4'hE, 4'hD, 4'b1110};
    tbl[11] = '{16'h0000, 5, 0, 4'hE, 4'hE, 4'hD, 4'b0111};

    // Reset state
    Reset = 1'b0;
    keys  = 16'h0;
    model_reset();
    repeat (3) @(negedge IntOsc);
    chk("reset_state", {3'd0, Cols, KeyCode, KeyValid, Digit1, Digit0}, {3'd0, 4'b1110, 4'h0, 1'b0, 4'h0, 4'h0});
    Reset = 1'b1;

    // Idle scanning walks the columns
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      do_tick();
      chk("idle_cols", {16'd0, Cols}, {16'd0, scan_exp[i]});
    end
    chk("idle_pulses", pulses, 0);
    chk("idle_digits", {12'd0, Digit1, Digit0}, 20'd0);

    // Table of press/release segments
    for (int v = 0; v < 12; v++) begin
      pulses = 0;
      run(tbl[v].mask, tbl[v].ticks);
      chk($sformatf("tbl%0d_pulses", v), pulses, tbl[v].npulse);
      chk($sformatf("tbl%0d_out", v), {4'd0, Cols, KeyCode, Digit1, Digit0},
          {4'd0, tbl[v].cols, tbl[v].code, tbl[v].d1, tbl[v].d0});
    end

    // Bouncy press and release of key A
    wait_col(3);
    pulses = 0;
    run(16'h0008, 1);
    run(16'h0000, 1);
    wait_col(3);
    run(16'h0008, 5);
    chk("bounce_press_pulses", pulses, 1);
    chk("bounce_code", {16'd0, KeyCode}, {16'd0, 4'hA});
    pulses = 0;
    run(16'h0000, 1);
    run(16'h0008, 1);
    run(16'h0000, 4);
    chk("bounce_release_pulses", pulses, 0);
    chk("bounce_resume_cols", {16'd0, Cols}, {16'd0, 4'b1101});

    // Asynchronous reset in the middle of a debounce
    wait_col(1);
    run(16'h0002, 2);
    #2 Reset = 1'b0;
    #1;
    chk("async_reset", {3'd0, Cols, KeyCode, KeyValid, Digit1, Digit0}, {3'd0, 4'b1110, 4'h0, 1'b0, 4'h0, 4'h0});
    for (int i = 0; i < 4; i++) begin
      @(negedge IntOsc);
      chk("reset_hold", {15'd0, KeyValid, Cols}, {15'd0, 1'b0, 4'b1110});
    end
    keys  = 16'h0;
    Reset = 1'b1;
    model_reset();

    // Long hold of key 9: auto-repeat only when the feature is built in
    wait_col(2);
    pulses = 0;
    run(16'h0400, 3 + 20);
`ifdef KEYPAD_REPEAT_EN
    chk("hold_pulses", pulses, 5);
`else
    chk("hold_pulses", pulses, 1);
`endif
    chk("hold_code", {16'd0, KeyCode}, {16'd0, 4'h9});
    run(16'h0000, 5);

    // Randomized key activity against the model
    for (int s = 0; s < 150; s++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) rmask = 16'h0;
      else if (sel < 8) rmask = 16'h1 << $urandom_range(0, 15);
      else if (sel == 8) rmask = (16'h1111 << $urandom_range(0, 3)) & 16'($urandom);
      else rmask = 16'($urandom) & 16'($urandom) & 16'($urandom);
      run(rmask, $urandom_range(1, 8));
    end
    run(16'h0000, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
